// File: rtl/uart_alu_pkg.sv
// Command codes, error-flag bit positions and FSM states shared by the
// UART/ALU command interface and its reply sequencer.
package uart_alu_pkg;

    localparam logic [7:0] CMD_A   = 8'h01;
    localparam logic [7:0] CMD_B   = 8'h02;
    localparam logic [7:0] CMD_OP  = 8'h03;
    localparam logic [7:0] CMD_R   = 8'h04;
    localparam logic [7:0] CMD_CLR = 8'h05;
    localparam logic [7:0] NAK     = 8'hEE;

    localparam int ERR_TIMEOUT = 0;
    localparam int ERR_UNKNOWN = 1;
    localparam int ERR_NAK     = 2;
    localparam int ERR_DROP    = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        LOAD_OP = 3'd3,
        TX_SEND = 3'd4,
        TX_WAIT = 3'd5
    } state_e;

endpackage

// File: rtl/uart_alu_cmd_if_if.sv
// Byte-level handshake between the UART RX/TX pair, the ALU and the command
// interface. The command interface is the slave; the UART/ALU side is the master.
interface uart_alu_cmd_if_if #(
    parameter int OPW  = 16,
    parameter int RESW = 16
);
    logic [7:0]      i_rx_data;
    logic            i_rx_valid;
    logic            i_tx_done;
    logic [RESW-1:0] i_result;
    logic [OPW-1:0]  o_a;
    logic [OPW-1:0]  o_b;
    logic [7:0]      o_op;
    logic [7:0]      o_tx_data;
    logic            o_tx_start;
    logic [2:0]      o_valid;
    logic [3:0]      o_err;
    logic            o_busy;

    modport master (
        output i_rx_data, i_rx_valid, i_tx_done, i_result,
        input  o_a, o_b, o_op, o_tx_data, o_tx_start, o_valid, o_err, o_busy
    );

    modport slave (
        input  i_rx_data, i_rx_valid, i_tx_done, i_result,
        output o_a, o_b, o_op, o_tx_data, o_tx_start, o_valid, o_err, o_busy
    );
endinterface

// File: rtl/uart_alu_cmd_if_tx_seq.sv
// Reply sequencer: snapshots a result word (or a lone NAK) and feeds it to
// UART TX one byte at a time, LSB first, over the start/done handshake.
// state   | meaning
// IDLE    | no burst in flight, waiting for i_load
// TX_SEND | o_tx_start high for this one cycle, o_tx_data = byte idx
// TX_WAIT | waiting for i_tx_done of byte idx
module uart_alu_tx_seq
    import uart_alu_pkg::*;
#(
    parameter int RESW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_nak,
    input  logic [RESW-1:0] i_word,
    input  logic            i_tx_done,
    output logic [7:0]      o_tx_data,
    output logic            o_tx_start,
    output logic            o_done
);

    localparam int RB = RESW / 8;
    localparam int IW = (RB > 1) ? $clog2(RB) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(RB - 1);

    state_e          state_q, state_d;
    logic [RESW-1:0] shift_q, shift_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   last_q, last_d;
    logic [7:0]      data_q, data_d;
    logic            start_q, start_d;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        last_d  = last_q;
        data_d  = data_q;
        start_d = 1'b0;
        o_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_load) begin
                    shift_d = i_word;
                    last_d  = IDX_LAST;
                    if (i_nak) begin
                        shift_d      = '0;
                        shift_d[7:0] = NAK;
                        last_d       = '0;
                    end
                    idx_d   = '0;
                    data_d  = shift_d[7:0];
                    start_d = 1'b1;
                    state_d = TX_SEND;
                end
            end
            TX_SEND: state_d = TX_WAIT;
            TX_WAIT: begin
                if (i_tx_done) begin
                    if (idx_q != last_q) begin
                        idx_d   = idx_q + 1'b1;
                        data_d  = shift_q[8*idx_d +: 8];
                        start_d = 1'b1;
                        state_d = TX_SEND;
                    end else begin
                        o_done  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            data_q  <= data_d;
            start_q <= start_d;
        end
    end

    assign o_tx_data  = data_q;
    assign o_tx_start = start_q;

endmodule

// File: rtl/uart_alu_cmd_if.sv
// Command decoder for the UART-driven ALU: assembles little-endian operands,
// latches the opcode and answers read requests with a result burst or a NAK.
// state   | meaning
// IDLE    | waiting for a command byte
// LOAD_A  | collecting operand A bytes, LSB first
// LOAD_B  | collecting operand B bytes, LSB first
// LOAD_OP | waiting for the opcode byte
// TX_SEND | first byte of a reply being started
// TX_WAIT | reply in flight, ends on the sequencer's done pulse
module uart_alu_cmd_if
    import uart_alu_pkg::*;
#(
    parameter int OPW     = 16,
    parameter int RESW    = 16,
    parameter int TIMEOUT = 100000
) (
    input logic               clk,
    input logic               rst,
    uart_alu_cmd_if_if.slave  bus
);

    localparam int NB = OPW / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(NB - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [OPW-1:0]  shadow_q, shadow_d;
    logic [OPW-1:0]  a_q, a_d;
    logic [OPW-1:0]  b_q, b_d;
    logic [7:0]      op_q, op_d;
    logic [2:0]      valid_q, valid_d;
    logic [3:0]      err_q, err_d;
    logic            busy_q, busy_d;

    logic            tx_load;
    logic            tx_nak;
    logic            tx_done;
    logic            tmo_hit;
    logic [7:0]      tx_data;
    logic            tx_start;

    assign tmo_hit = (tmo_q == TMO_LAST);

    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        tmo_d    = tmo_q;
        shadow_d = shadow_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        valid_d  = valid_q;
        err_d    = err_q;
        tx_load  = 1'b0;
        tx_nak   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_rx_valid) begin
                    case (bus.i_rx_data)
                        CMD_A: begin
                            state_d = LOAD_A;
                            bcnt_d  = '0;
                            tmo_d   = '0;
                        end
                        CMD_B: begin
                            state_d = LOAD_B;
                            bcnt_d  = '0;
                            tmo_d   = '0;
                        end
                        CMD_OP: begin
                            state_d = LOAD_OP;
                            bcnt_d  = '0;
                            tmo_d   = '0;
                        end
                        CMD_R: begin
                            tx_load = 1'b1;
                            tx_nak  = (valid_q != 3'b111);
                            if (tx_nak) err_d[ERR_NAK] = 1'b1;
                            state_d = TX_SEND;
                        end
                        CMD_CLR: begin
                            err_d   = '0;
                            valid_d = '0;
                        end
                        default: err_d[ERR_UNKNOWN] = 1'b1;
                    endcase
                end
            end
            LOAD_A, LOAD_B: begin
                if (bus.i_rx_valid) begin
                    shadow_d[8*bcnt_q +: 8] = bus.i_rx_data;
                    tmo_d = '0;
                    // Commit the whole word at once so the ALU never sees a half-loaded operand.
                    if (bcnt_q == BYTE_LAST) begin
                        if (state_q == LOAD_A) begin
                            a_d        = shadow_d;
                            valid_d[0] = 1'b1;
                        end else begin
                            b_d        = shadow_d;
                            valid_d[1] = 1'b1;
                        end
                        state_d = IDLE;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end else if (tmo_hit) begin
                    shadow_d             = '0;
                    err_d[ERR_TIMEOUT]   = 1'b1;
                    tmo_d                = '0;
                    state_d              = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            LOAD_OP: begin
                if (bus.i_rx_valid) begin
                    op_d       = bus.i_rx_data;
                    valid_d[2] = 1'b1;
                    tmo_d      = '0;
                    state_d    = IDLE;
                end else if (tmo_hit) begin
                    err_d[ERR_TIMEOUT] = 1'b1;
                    tmo_d              = '0;
                    state_d            = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            TX_SEND: begin
                if (bus.i_rx_valid) err_d[ERR_DROP] = 1'b1;
                state_d = TX_WAIT;
            end
            TX_WAIT: begin
                if (bus.i_rx_valid) err_d[ERR_DROP] = 1'b1;
                if (tx_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            bcnt_q   <= '0;
            tmo_q    <= '0;
            shadow_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            valid_q  <= '0;
            err_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcnt_q   <= bcnt_d;
            tmo_q    <= tmo_d;
            shadow_q <= shadow_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    uart_alu_tx_seq #(
        .RESW (RESW)
    ) u_tx_seq (
        .clk        (clk),
        .rst        (rst),
        .i_load     (tx_load),
        .i_nak      (tx_nak),
        .i_word     (bus.i_result),
        .i_tx_done  (bus.i_tx_done),
        .o_tx_data  (tx_data),
        .o_tx_start (tx_start),
        .o_done     (tx_done)
    );

    assign bus.o_a        = a_q;
    assign bus.o_b        = b_q;
    assign bus.o_op       = op_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_err      = err_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_tx_data  = tx_data;
    assign bus.o_tx_start = tx_start;

endmodule
